vc_packet_fifo: RTL and testbench
=================================

# vc_packet_fifo

Multi-channel packet buffer with NUM_CH independent per-channel FIFOs behind a single write port and a single round-robin-arbitrated, registered valid/ready output. Successor to the single-channel packet FIFO, adding per-channel flow control, almost-full status, per-channel flush and a back-pressurable output stage. Sits between the link-layer packet decoder (writer, channel = virtual channel/traffic class) and the downstream packet consumer.

## Interface
- PACKET_WIDTH, 128, packet width in bits
- DEPTH, 8, entries per channel; power of two, ≥ 2
- NUM_CH, 4, number of channels; ≥ 1
- AFULL_THRESH, DEPTH-2, ch_afull[c] asserted when count[c] ≥ this value; 1..DEPTH
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  write request
- wr_ch  in  CH_W  target channel; CH_W = max(1, $clog2(NUM_CH))
- wr_data  in  PACKET_WIDTH  packet
- wr_ready  out  1  = !ch_full[wr_ch]; combinational from wr_ch
- ch_flush  in  NUM_CH  per-channel synchronous flush
- out_valid  out  1  output register holds a packet
- out_ch  out  CH_W  source channel of out_data
- out_data  out  PACKET_WIDTH  packet
- out_ready  in  1  consumer accepts
- ch_full  out  NUM_CH  count[c] == DEPTH
- ch_afull  out  NUM_CH  count[c] ≥ AFULL_THRESH
- ch_empty  out  NUM_CH  count[c] == 0

## Operation
- Per channel: mem[DEPTH], wr_ptr/rd_ptr/count, each ADDR_W+1 bits; pointers wrap at DEPTH via low ADDR_W bits.
- Write accepted when wr_valid && wr_ready && !ch_flush[wr_ch]: store at wr_ptr, increment wr_ptr and count. wr_valid && !wr_ready: packet dropped, no state change.
- Full is based on registered count: a write to a full channel is refused even when the same channel pops in that cycle.
- Output load condition: (!out_valid || out_ready) and at least one channel is non-empty and not flushing. The arbiter grants one channel; at the edge, mem[rd_ptr] loads into out_data, out_ch is set to the granted channel, out_valid goes to 1, and that channel's rd_ptr increments and count decrements.
- Load condition true but no eligible channel: out_valid goes to 0 if out_ready was high.
- Holding: while out_valid && !out_ready, out_data and out_ch stay stable and no pop occurs.
- Arbitration is round-robin. The search starts at (last_grant+1) mod NUM_CH. last_grant updates only on a load. After reset, last_grant = NUM_CH-1, so channel 0 has highest priority.
- Simultaneous write and pop on the same channel: both take effect and count is unchanged.
- ch_flush[c]: at the edge, wr_ptr, rd_ptr and count of channel c are cleared to 0. Flush wins over a same-cycle write or pop on c. The output register is not affected, even if it holds a packet from c.
- rst: all pointers and counts go to 0, last_grant = NUM_CH-1. Memory contents are not reset.

## Timing
- Reset values: out_valid=0, out_ch=0, out_data=0, ch_full=0, ch_afull=0 (for AFULL_THRESH>0), ch_empty=all-1, wr_ready=1.
- Write-to-output latency into an idle block: write accepted in cycle N, out_valid high in cycle N+2. There is no bypass path.
- Sustained throughput: 1 packet/cycle while out_ready=1 and data is available.
- ch_full, ch_afull and ch_empty are registered-count-derived; each updates the cycle after the causing write, pop or flush.
- Handshake transfers when out_valid && out_ready at the edge.

## Structure
- Package vc_fifo_pkg holds: the CH_W computation function and the packet-width default constant shared with the link-layer decoder.
- One sub-module, vc_fifo_chan: a single-channel storage with push/pop/flush inputs and count/full/afull/empty outputs, instantiated NUM_CH times.
- The top level contains the write demux, the round-robin arbiter and the output register.

## Test plan
- Reset, then write 0xA1 to ch2 in cycle 1 → out_valid=1, out_ch=2, out_data=0xA1 in cycle 3; ch_empty=4'b1111 after the pop.
- With out_ready=0, fill ch0 with 8 writes; a 9th write 0xFF sees wr_ready=0 and is dropped → ch_full[0]=1, ch_afull[0] set after the 6th write; draining yields exactly the 8 packets in order.
- One packet each in ch0..ch3, out_ready=1 → out_ch sequence 0,1,2,3. Then ch1 and ch3 loaded twice each → sequence 1,3,1,3.
- Hold out_ready=0 for 5 cycles with out_valid=1 → out_data and out_ch stable, counts unchanged. Then release → next packet on the following cycle.
- ch_flush[1] in the same cycle as a write to ch1 while ch1 holds 3 packets → ch1 count=0 and ch_empty[1]=1 next cycle; the packet already in the output register is still delivered.
- Simultaneous write and pop on a ch0 holding 4 packets, for 20 cycles → count stays 4, FIFO order is preserved across pointer wrap.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// Shared definitions for the virtual-channel packet FIFO and the link-layer decoder.
package vc_fifo_pkg;

  localparam int PACKET_WIDTH_DEFAULT = 128;

  // Channel-index width; a single channel still gets a 1-bit index.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/vc_packet_fifo_if.sv
// Write port and registered valid/ready output port of vc_packet_fifo.
interface vc_packet_fifo_if
  import vc_fifo_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEFAULT,
  parameter int CH_W         = 2
);

  logic                    wr_valid;
  logic [CH_W-1:0]         wr_ch;
  logic [PACKET_WIDTH-1:0] wr_data;
  logic                    wr_ready;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [PACKET_WIDTH-1:0] out_data;
  logic                    out_ready;

  modport master (
    output wr_valid, wr_ch, wr_data, out_ready,
    input  wr_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  wr_valid, wr_ch, wr_data, out_ready,
    output wr_ready, out_valid, out_ch, out_data
  );

endinterface

// File: rtl/vc_fifo_chan.sv
// Single-channel packet storage with push/pop/flush and count-derived status flags.
module vc_fifo_chan #(
  parameter int WIDTH        = 128,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             afull,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C = AFULL_THRESH[ADDR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign full    = (count == DEPTH_C);
  assign afull   = (count >= AFULL_C);
  assign empty   = (count == '0);

endmodule

// File: rtl/vc_packet_fifo.sv
// Multi-channel packet buffer: write demux, round-robin arbiter, registered output stage.
module vc_packet_fifo
  import vc_fifo_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEFAULT,
  parameter int DEPTH        = 8,
  parameter int NUM_CH       = 4,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst,
  vc_packet_fifo_if.slave   bus,
  input  logic [NUM_CH-1:0] ch_flush,
  output logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_afull,
  output logic [NUM_CH-1:0] ch_empty
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       eligible;
  logic [PACKET_WIDTH-1:0] rd_data [NUM_CH];
  logic [PACKET_WIDTH-1:0] grant_data;
  logic [CH_W-1:0]         last_grant;
  logic [CH_W-1:0]         grant_ch;
  logic                    grant_valid;
  logic                    load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vc_fifo_chan #(
      .WIDTH        (PACKET_WIDTH),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (bus.wr_data),
      .pop       (pop[g]),
      .flush     (ch_flush[g]),
      .rd_data   (rd_data[g]),
      .full      (ch_full[g]),
      .afull     (ch_afull[g]),
      .empty     (ch_empty[g])
    );
  end

  // Out-of-range wr_ch (non power-of-two NUM_CH) reads as ready but never pushes.
  always_comb begin
    bus.wr_ready = 1'b1;
    push         = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.wr_ch == CH_W'(c)) begin
        bus.wr_ready = !ch_full[c];
        push[c]      = bus.wr_valid && !ch_full[c] && !ch_flush[c];
      end
    end
  end

  always_comb begin
    int unsigned idx;
    eligible    = ~ch_empty & ~ch_flush;
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(last_grant) + 1 + i) % NUM_CH;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    load       = (!bus.out_valid || bus.out_ready) && grant_valid;
    pop        = '0;
    grant_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_ch == CH_W'(c)) begin
        grant_data = rd_data[c];
        pop[c]     = load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
      last_grant    <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_ch    <= grant_ch;
      bus.out_data  <= grant_data;
      last_grant    <= grant_ch;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_packet_fifo.sv
// Scoreboard bench for vc_packet_fifo: latency, full/afull, round-robin order, hold, flush, wrap.
module tb_vc_packet_fifo;
  import vc_fifo_pkg::*;

  localparam int PW     = 128;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = ch_width(NUM_CH);

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [PW-1:0]   data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0] ch_flush, ch_full, ch_afull, ch_empty;

  always #5 clk = ~clk;

  vc_packet_fifo_if #(.PACKET_WIDTH(PW), .CH_W(CH_W)) bus ();

  vc_packet_fifo #(
    .PACKET_WIDTH (PW),
    .DEPTH        (DEPTH),
    .NUM_CH       (NUM_CH),
    .AFULL_THRESH (DEPTH - 2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ch_flush (ch_flush),
    .ch_full  (ch_full),
    .ch_afull (ch_afull),
    .ch_empty (ch_empty)
  );

  pkt_t            sb[$];
  logic [CH_W-1:0] exp_ch_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_deliv  = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input logic [PW-1:0] d, input logic exp_ready, input logic accept);
    bus.wr_valid = 1'b1;
    bus.wr_ch    = CH_W'(ch);
    bus.wr_data  = d;
    #1;
    check("wr_ready", bus.wr_ready, exp_ready);
    if (accept) sb.push_back('{ch: CH_W'(ch), data: d});
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    check("order_q_empty", exp_ch_q.size(), 0);
    tick();
  endtask

  always @(negedge clk) begin
    int idx;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_deliv++;
      idx = -1;
      if (exp_ch_q.size() > 0) check("rr_order", bus.out_ch, exp_ch_q.pop_front());
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].ch == bus.out_ch) idx = i;
      check("sb_hit", idx >= 0, 1);
      if (idx >= 0) begin
        check("out_data", bus.out_data, sb[idx].data);
        sb.delete(idx);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    pkt_t keep[$];
    bit   seen;

    rst          = 1'b1;
    ch_flush     = '0;
    bus.wr_valid = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_full", ch_full, 0);
    check("rst_afull", ch_afull, 0);
    check("rst_empty", ch_empty, 4'b1111);
    check("rst_wr_ready", bus.wr_ready, 1);
    rst = 1'b0;

    // Latency: accepted in N, visible in N+2
    exp_ch_q.push_back(2);
    write(2, 'hA1, 1, 1);
    check("lat_n1_valid", bus.out_valid, 0);
    tick();
    check("lat_n2_valid", bus.out_valid, 1);
    check("lat_n2_ch", bus.out_ch, 2);
    check("lat_n2_data", bus.out_data, 'hA1);
    tick();
    check("lat_empty", ch_empty, 4'b1111);
    check("lat_valid_drop", bus.out_valid, 0);

    // Fill ch0 behind a held ch3 packet
    bus.out_ready = 1'b0;
    write(3, 'h33, 1, 1);
    tick();
    check("hold3_valid", bus.out_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      write(0, PW'('h100 + i), 1, 1);
      check("fill_afull0", ch_afull[0], i >= 5);
    end
    check("fill_full0", ch_full[0], 1);
    write(0, 'hFF, 0, 0);
    check("drop_full0", ch_full[0], 1);
    exp_ch_q.push_back(3);
    for (int i = 0; i < DEPTH; i++) exp_ch_q.push_back(0);
    bus.out_ready = 1'b1;
    wait_drain(40);
    check("fill_idle", bus.out_valid, 0);

    // Round robin 0,1,2,3
    bus.out_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_ch_q.push_back(CH_W'(c));
      write(c, PW'('h200 + c), 1, 1);
    end
    bus.out_ready = 1'b1;
    wait_drain(20);

    // Round robin 1,3,1,3
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_ch_q.push_back((k % 2 == 0) ? 1 : 3);
      write((k % 2 == 0) ? 1 : 3, PW'('h300 + k), 1, 1);
    end
    bus.out_ready = 1'b1;
    wait_drain(20);

    // Hold stability
    bus.out_ready = 1'b0;
    write(2, 'hB0, 1, 1);
    write(2, 'hB1, 1, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, 'hB0);
      check("hold_ch", bus.out_ch, 2);
      check("hold_empty2", ch_empty[2], 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("release_next", bus.out_data, 'hB1);
    wait_drain(10);

    // Flush ch1 while its head sits in the output register
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write(1, PW'('hC0 + i), 1, 1);
    tick();
    check("preflush_empty1", ch_empty[1], 0);
    ch_flush = 4'b0010;
    write(1, 'hCF, 1, 0);
    ch_flush = '0;
    check("flush_empty1", ch_empty[1], 1);
    check("flush_afull1", ch_afull[1], 0);
    check("flush_keep_valid", bus.out_valid, 1);
    check("flush_keep_data", bus.out_data, 'hC0);
    seen = 1'b0;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].ch != 1 || !seen) begin
        keep.push_back(sb[i]);
        if (sb[i].ch == 1) seen = 1'b1;
      end
    end
    sb = keep;
    bus.out_ready = 1'b1;
    wait_drain(10);
    tick();
    check("flush_idle", bus.out_valid, 0);

    // Simultaneous write/pop on ch0 with 4 stored, across pointer wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write(0, PW'('hD0 + i), 1, 1);
    tick();
    base = n_deliv;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write(0, PW'('hE00 + i), 1, 1);
      check("wp_afull0", ch_afull[0], 0);
      check("wp_empty0", ch_empty[0], 0);
    end
    bus.out_ready = 1'b0;
    write(0, 'hF00, 1, 1);
    check("wp_count5", ch_afull[0], 0);
    write(0, 'hF01, 1, 1);
    check("wp_count6", ch_afull[0], 1);
    bus.out_ready = 1'b1;
    wait_drain(40);
    check("wp_deliveries", n_deliv - base, 27);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
